// File: rtl/isr_pkg.sv
// isr_pkg: shared widths and state encoding for the integer square root datapath
package isr_pkg;
  localparam int ROOT_W = 32;
  localparam int VAL_W = 2 * ROOT_W;
  localparam int CNT_W = $clog2(ROOT_W);
  typedef enum logic [1:0] {IDLE, SQUARE, CHECK, DONE} state_t;
endpackage

// File: rtl/isr_check_sq_serial.sv
// sq_serial: radix-2 msb-first shift-add squarer
module sq_serial
  import isr_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [ROOT_W-1:0] root,
  output logic              busy,
  output logic [VAL_W-1:0]  acc
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clock)
    if (reset) begin
      acc  <= '0;
      cnt  <= CNT_W'(ROOT_W - 1);
      busy <= 1'b0;
    end else if (load) begin
      acc  <= '0;
      cnt  <= CNT_W'(ROOT_W - 1);
      busy <= 1'b1;
    end else if (busy) begin
      acc  <= (acc << 1) + (root[cnt] ? VAL_W'(root) : '0);
      cnt  <= cnt - 1'b1;
      busy <= cnt != '0;
    end
endmodule

// File: rtl/isr_check.sv
// isr_check: squares a candidate root and brackets it against a value
module isr_check
  import isr_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ROOT_W-1:0] root,
  input  logic [VAL_W-1:0]  value,
  output logic [VAL_W-1:0]  square,
  output logic              over,
  output logic              under,
  output logic              valid,
  output logic              busy,
  output logic              done
);
  state_t state;
  logic [ROOT_W-1:0] r_root;
  logic [VAL_W-1:0] r_val, acc;
  logic [VAL_W:0] hi;
  logic sq_busy, load;
  always_comb begin
    load = start && (state == IDLE || state == DONE);
    hi = {1'b0, acc} + {{ROOT_W{1'b0}}, r_root, 1'b0} + 1'b1;
  end
  sq_serial u_sq (
    .clock(clock),
    .reset(reset),
    .load(load),
    .root(r_root),
    .busy(sq_busy),
    .acc(acc)
  );
  always_ff @(posedge clock)
    if (reset) begin
      state  <= IDLE;
      r_root <= '0;
      r_val  <= '0;
      square <= '0;
      over   <= 1'b0;
      under  <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          r_root <= root;
          r_val  <= value;
          busy   <= 1'b1;
          done   <= 1'b0;
          state  <= SQUARE;
        end
        SQUARE: if (!sq_busy) state <= CHECK;
        CHECK: begin
          square <= acc;
          over   <= acc > r_val;
          under  <= {1'b0, r_val} >= hi;
          valid  <= !(acc > r_val) && !({1'b0, r_val} >= hi);
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_isr_check.sv
// tb_isr_check: scoreboard bench for isr_check
module tb_isr_check;
  typedef struct packed {
    logic [63:0] square;
    logic over;
    logic under;
    logic valid;
  } exp_t;
  logic clock = 0, reset = 1, start = 0;
  logic [31:0] root = 0;
  logic [63:0] value = 0;
  logic [63:0] square;
  logic over, under, valid, busy, done;
  int checks = 0, errors = 0;
  exp_t exp_q[$];
  isr_check dut (
    .clock(clock), .reset(reset), .start(start), .root(root), .value(value),
    .square(square), .over(over), .under(under), .valid(valid), .busy(busy), .done(done)
  );
  always #5 clock = ~clock;
  function automatic exp_t model(input logic [31:0] r, input logic [63:0] v);
    logic [65:0] a, b, sq, nx;
    a = {34'b0, r};
    b = a + 66'd1;
    sq = a * a;
    nx = b * b;
    model.square = sq[63:0];
    model.over = sq > {2'b0, v};
    model.under = {2'b0, v} >= nx;
    model.valid = !model.over && !model.under;
  endfunction
  task automatic launch(input logic [31:0] r, input logic [63:0] v);
    @(negedge clock);
    root = r;
    value = v;
    start = 1;
    exp_q.push_back(model(r, v));
    @(posedge clock);
    @(negedge clock);
    start = 0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clock);
      @(negedge clock);
      n++;
    end
  endtask
  task automatic test_reset;
    reset = 1;
    start = 1;
    root = 32'd5;
    value = 64'd25;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({square, over, under, valid, busy, done} !== 69'd0) begin
      errors++;
      $display("FAIL reset_outputs: got sq=%h o=%b u=%b v=%b busy=%b done=%b, want all 0",
               square, over, under, valid, busy, done);
    end
    start = 0;
    reset = 0;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask
  task automatic test_vectors;
    logic [31:0] rs[10];
    logic [63:0] vs[10];
    exp_t e;
    int n;
    rs = '{32'd3, 32'd4, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd12345, 32'd12345, 32'd65536, 32'd7, 32'd0};
    vs = '{64'd10, 64'd15, 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd152399025, 64'd152399024,
           64'h1_0002_0000, 64'd64, 64'd0};
    rs[9] = $urandom;
    vs[9] = {32'b0, rs[9]} * {32'b0, rs[9]} + 64'($urandom_range(0, 3)) * {32'b0, rs[9]};
    for (int i = 0; i < 10; i++) begin
      launch(rs[i], vs[i]);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_busy: got busy=%b done=%b, want 1 0", i, busy, done);
      end
      wait_done(n);
      e = exp_q.pop_front();
      checks++;
      if (n !== 34) begin
        errors++;
        $display("FAIL vec%0d_latency: got %0d cycles, want 34", i, n);
      end
      checks++;
      if ({square, over, under, valid} !== e) begin
        errors++;
        $display("FAIL vec%0d_result: got sq=%h o=%b u=%b v=%b, want sq=%h o=%b u=%b v=%b", i,
                 square, over, under, valid, e.square, e.over, e.under, e.valid);
      end
      checks++;
      if (over && under) begin
        errors++;
        $display("FAIL vec%0d_exclusive: got over=1 under=1, want not both", i);
      end
    end
  endtask
  task automatic test_ignore_start;
    exp_t e;
    int n;
    launch(32'd1000, 64'd1000000);
    repeat (9) begin
      @(posedge clock);
      @(negedge clock);
    end
    root = 32'd9;
    value = 64'd2;
    start = 1;
    @(posedge clock);
    @(negedge clock);
    start = 0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_busy: got busy=%b, want 1", busy);
    end
    wait_done(n);
    e = exp_q.pop_front();
    checks++;
    if (n + 10 !== 34) begin
      errors++;
      $display("FAIL ignore_latency: got %0d cycles, want 34", n + 10);
    end
    checks++;
    if ({square, over, under, valid} !== e) begin
      errors++;
      $display("FAIL ignore_result: got sq=%h o=%b u=%b v=%b, want sq=%h o=%b u=%b v=%b",
               square, over, under, valid, e.square, e.over, e.under, e.valid);
    end
  endtask
  task automatic test_reset_mid;
    exp_t e;
    int n;
    launch(32'd77, 64'd6000);
    repeat (19) begin
      @(posedge clock);
      @(negedge clock);
    end
    reset = 1;
    @(posedge clock);
    @(negedge clock);
    reset = 0;
    void'(exp_q.pop_front());
    checks++;
    if ({square, over, under, valid, busy, done} !== 69'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got sq=%h o=%b u=%b v=%b busy=%b done=%b, want all 0",
               square, over, under, valid, busy, done);
    end
    repeat (40) @(negedge clock);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_nodone: got done=%b, want 0", done);
    end
    launch(32'd300, 64'd90600);
    wait_done(n);
    e = exp_q.pop_front();
    checks++;
    if (n !== 34) begin
      errors++;
      $display("FAIL midreset_latency: got %0d cycles, want 34", n);
    end
    checks++;
    if ({square, over, under, valid} !== e) begin
      errors++;
      $display("FAIL midreset_result: got sq=%h o=%b u=%b v=%b, want sq=%h o=%b u=%b v=%b",
               square, over, under, valid, e.square, e.over, e.under, e.valid);
    end
  endtask
  task automatic test_back_to_back;
    exp_t e;
    int n;
    launch(32'd11, 64'd121);
    wait_done(n);
    e = exp_q.pop_front();
    root = 32'd20;
    value = 64'd500;
    start = 1;
    exp_q.push_back(model(32'd20, 64'd500));
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || square !== e.square) begin
      errors++;
      $display("FAIL b2b_relaunch: got busy=%b done=%b sq=%h, want 1 0 %h", busy, done, square, e.square);
    end
    repeat (5) begin
      @(posedge clock);
      @(negedge clock);
    end
    start = 0;
    wait_done(n);
    e = exp_q.pop_front();
    checks++;
    if (n + 5 !== 34) begin
      errors++;
      $display("FAIL b2b_latency: got %0d cycles, want 34", n + 5);
    end
    checks++;
    if ({square, over, under, valid} !== e) begin
      errors++;
      $display("FAIL b2b_result: got sq=%h o=%b u=%b v=%b, want sq=%h o=%b u=%b v=%b",
               square, over, under, valid, e.square, e.over, e.under, e.valid);
    end
  endtask
  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
